// File: rtl/alu48_issue_if.sv
// Request/response bundle for the 48-bit ALU issue sequencer.
// The requester uses the master modport and the sequencer uses the slave modport.
interface alu48_issue_if #(
  parameter int W = 48
);
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_cmd;
  logic [W-1:0] req_a;
  logic [W-1:0] req_d;
  logic [5:0]   req_shamt;
  logic         req_swap;
  logic [3:0]   req_tag;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_y;
  logic         rsp_eq;
  logic         rsp_lt_s;
  logic         rsp_lt_u;
  logic [3:0]   rsp_tag;
  logic         rsp_err;

  modport master (
    output req_valid, req_cmd, req_a, req_d, req_shamt, req_swap, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_y, rsp_eq, rsp_lt_s, rsp_lt_u, rsp_tag, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_cmd, req_a, req_d, req_shamt, req_swap, req_tag,
    output req_ready,
    output rsp_valid, rsp_y, rsp_eq, rsp_lt_s, rsp_lt_u, rsp_tag, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu48_issue.sv
// Issue sequencer for the combinational 48-bit ALU: latches requests, drives the ALU, returns results.
// Define ALU48_ISSUE_ROTATE_EN to build ROL/ROR (commands 9/10) as three ALU passes.
module alu48_issue #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  alu48_issue_if.slave bus,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [5:0]   alu_op,
  output logic [5:0]   alu_shamt,
  input  logic [W-1:0] alu_y,
  input  logic         alu_eq,
  input  logic         alu_lt_s,
  input  logic         alu_lt_u
);

  localparam logic [5:0] SHAMT_LIMIT = 6'(W);

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_AND = 4'd2;
  localparam logic [3:0] CMD_OR  = 4'd3;
  localparam logic [3:0] CMD_XOR = 4'd4;
  localparam logic [3:0] CMD_SLL = 4'd5;
  localparam logic [3:0] CMD_SRL = 4'd6;
  localparam logic [3:0] CMD_SRA = 4'd7;
  localparam logic [3:0] CMD_NOT = 4'd8;

`ifdef ALU48_ISSUE_ROTATE_EN
  localparam logic [3:0] CMD_ROL = 4'd9;
  localparam logic [3:0] CMD_ROR = 4'd10;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_SLL  = 6'h05;
  localparam logic [5:0] OP_SRL  = 6'h06;

  typedef enum logic [2:0] {IDLE, P1, P2, P3, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, P1, RESP} state_t;
`endif

  state_t state_reg, state_next;

  logic [W-1:0] a_reg, b_reg;
  logic [5:0]   op_reg, shamt_reg;
  logic [3:0]   tag_reg;
  logic [W-1:0] rsp_y_reg;
  logic         rsp_eq_reg, rsp_lt_s_reg, rsp_lt_u_reg, rsp_err_reg;
`ifdef ALU48_ISSUE_ROTATE_EN
  logic         rot_reg;
  logic [W-1:0] t1_reg, t2_reg;
`endif

  logic         req_rot, req_shift, req_err, req_swap_ok;
  logic [5:0]   req_op, req_shamt_eff;
  logic         can_accept, accept;

  // Request decode; ROR by s is issued as ROL by W-s so only one rotate schedule exists.
  always_comb begin
    req_rot       = 1'b0;
    req_op        = {2'b00, bus.req_cmd};
    req_shamt_eff = bus.req_shamt;
`ifdef ALU48_ISSUE_ROTATE_EN
    if (bus.req_cmd == CMD_ROL || bus.req_cmd == CMD_ROR) begin
      req_rot = 1'b1;
      req_op  = OP_SLL;
      if (bus.req_cmd == CMD_ROR && bus.req_shamt != 6'd0)
        req_shamt_eff = SHAMT_LIMIT - bus.req_shamt;
    end
`endif
    req_shift = (bus.req_cmd == CMD_SLL) || (bus.req_cmd == CMD_SRL) ||
                (bus.req_cmd == CMD_SRA) || req_rot;
    req_err   = ((bus.req_cmd > CMD_NOT) && !req_rot) ||
                (req_shift && (bus.req_shamt >= SHAMT_LIMIT));
    req_swap_ok = bus.req_swap &&
                  ((bus.req_cmd == CMD_ADD) || (bus.req_cmd == CMD_AND) ||
                   (bus.req_cmd == CMD_OR)  || (bus.req_cmd == CMD_XOR));
  end

  assign accept = bus.req_valid && can_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next state plus ALU drive; the ALU only ever sees registered operands.
  always_comb begin
    state_next = state_reg;
    can_accept = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = 6'h00;
    alu_shamt  = 6'd0;
    case (state_reg)
      IDLE: begin
        can_accept = 1'b1;
        if (bus.req_valid)
          state_next = req_err ? RESP : P1;
      end
      P1: begin
        alu_a     = a_reg;
        alu_b     = b_reg;
        alu_op    = op_reg;
        alu_shamt = shamt_reg;
`ifdef ALU48_ISSUE_ROTATE_EN
        state_next = rot_reg ? P2 : RESP;
`else
        state_next = RESP;
`endif
      end
`ifdef ALU48_ISSUE_ROTATE_EN
      P2: begin
        alu_a      = a_reg;
        alu_op     = OP_SRL;
        alu_shamt  = SHAMT_LIMIT - shamt_reg;
        state_next = P3;
      end
      P3: begin
        alu_a      = t1_reg;
        alu_b      = t2_reg;
        alu_op     = OP_OR;
        state_next = RESP;
      end
`endif
      RESP: begin
        if (bus.rsp_ready) begin
          can_accept = 1'b1;
          if (bus.req_valid)
            state_next = req_err ? RESP : P1;
          else
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= 6'h00;
      shamt_reg    <= 6'd0;
      tag_reg      <= 4'd0;
      rsp_y_reg    <= '0;
      rsp_eq_reg   <= 1'b0;
      rsp_lt_s_reg <= 1'b0;
      rsp_lt_u_reg <= 1'b0;
      rsp_err_reg  <= 1'b0;
`ifdef ALU48_ISSUE_ROTATE_EN
      rot_reg      <= 1'b0;
      t1_reg       <= '0;
      t2_reg       <= '0;
`endif
    end else begin
      if (accept) begin
        a_reg     <= req_swap_ok ? bus.req_d : bus.req_a;
        b_reg     <= req_swap_ok ? bus.req_a : bus.req_d;
        op_reg    <= req_op;
        shamt_reg <= req_shamt_eff;
        tag_reg   <= bus.req_tag;
`ifdef ALU48_ISSUE_ROTATE_EN
        rot_reg   <= req_rot && (bus.req_shamt != 6'd0);
`endif
        // Errors skip the ALU entirely and respond with a zeroed payload.
        if (req_err) begin
          rsp_y_reg    <= '0;
          rsp_eq_reg   <= 1'b0;
          rsp_lt_s_reg <= 1'b0;
          rsp_lt_u_reg <= 1'b0;
          rsp_err_reg  <= 1'b1;
        end
      end
      if (state_reg == P1) begin
        rsp_eq_reg   <= alu_eq;
        rsp_lt_s_reg <= alu_lt_s;
        rsp_lt_u_reg <= alu_lt_u;
        rsp_err_reg  <= 1'b0;
`ifdef ALU48_ISSUE_ROTATE_EN
        if (rot_reg)
          t1_reg <= alu_y;
        else
          rsp_y_reg <= alu_y;
`else
        rsp_y_reg <= alu_y;
`endif
      end
`ifdef ALU48_ISSUE_ROTATE_EN
      if (state_reg == P2)
        t2_reg <= alu_y;
      if (state_reg == P3)
        rsp_y_reg <= alu_y;
`endif
    end
  end

  assign bus.req_ready = can_accept;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_y     = rsp_y_reg;
  assign bus.rsp_eq    = rsp_eq_reg;
  assign bus.rsp_lt_s  = rsp_lt_s_reg;
  assign bus.rsp_lt_u  = rsp_lt_u_reg;
  assign bus.rsp_tag   = tag_reg;
  assign bus.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_alu48_issue.sv
// Directed self-checking bench for alu48_issue with a behavioural ALU attached.
// Rotate vectors run when ALU48_ISSUE_ROTATE_EN is defined, otherwise commands 9/10 are checked as illegal.
module tb_alu48_issue;

  logic        clk;
  logic        rst_n;
  logic [47:0] alu_a, alu_b, alu_y;
  logic [5:0]  alu_op, alu_shamt;
  logic        alu_eq, alu_lt_s, alu_lt_u;

  int assert_count = 0;
  int fail_count   = 0;
  int cur_tag      = 0;

  alu48_issue_if #(.W(48)) bus ();

  alu48_issue #(.W(48)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_shamt(alu_shamt),
    .alu_y    (alu_y),
    .alu_eq   (alu_eq),
    .alu_lt_s (alu_lt_s),
    .alu_lt_u (alu_lt_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference combinational ALU.
  always_comb begin
    alu_y = '0;
    case (alu_op)
      6'h00: alu_y = alu_a + alu_b;
      6'h01: alu_y = alu_a - alu_b;
      6'h02: alu_y = alu_a & alu_b;
      6'h03: alu_y = alu_a | alu_b;
      6'h04: alu_y = alu_a ^ alu_b;
      6'h05: alu_y = alu_a << alu_shamt;
      6'h06: alu_y = alu_a >> alu_shamt;
      6'h07: alu_y = 48'($signed(alu_a) >>> alu_shamt);
      6'h08: alu_y = ~alu_a;
      default: alu_y = '0;
    endcase
    alu_eq   = (alu_a == alu_b);
    alu_lt_s = ($signed(alu_a) < $signed(alu_b));
    alu_lt_u = (alu_a < alu_b);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL txn%0d %s: got %h expected %h", cur_tag, tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [3:0] cmd, input logic [47:0] a, input logic [47:0] d,
                           input logic [5:0] sh, input logic sw, input logic [3:0] tag);
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_a     = a;
    bus.req_d     = d;
    bus.req_shamt = sh;
    bus.req_swap  = sw;
    bus.req_tag   = tag;
  endtask

  // Issue one request, measure latency from the accept edge, check the response, then consume it.
  task automatic do_txn(input logic [3:0] cmd, input logic [47:0] a, input logic [47:0] d,
                        input logic [5:0] sh, input logic sw, input logic [3:0] tag,
                        input int exp_lat, input logic [47:0] exp_y, input logic exp_eq,
                        input logic exp_lts, input logic exp_ltu, input logic exp_err);
    int lat;
    cur_tag = tag;
    check("req_ready_before", 64'(bus.req_ready), 64'd1);
    drive_req(cmd, a, d, sh, sw, tag);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("rsp_y", 64'(bus.rsp_y), 64'(exp_y));
    check("flags", 64'({bus.rsp_eq, bus.rsp_lt_s, bus.rsp_lt_u}), 64'({exp_eq, exp_lts, exp_ltu}));
    check("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    check("rsp_tag", 64'(bus.rsp_tag), 64'(tag));
    if (exp_err) begin
      check("alu_op_idle", 64'(alu_op), 64'd0);
      check("alu_ops_idle", 64'({alu_a, alu_b, alu_shamt} != '0), 64'd0);
    end
    $display("txn tag=%0d cmd=%0d a=%h d=%h sh=%0d y=%h flags=%b err=%0b lat=%0d",
             tag, cmd, a, d, sh, bus.rsp_y, {bus.rsp_eq, bus.rsp_lt_s, bus.rsp_lt_u},
             bus.rsp_err, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 4'd0;
    bus.req_a     = '0;
    bus.req_d     = '0;
    bus.req_shamt = 6'd0;
    bus.req_swap  = 1'b0;
    bus.req_tag   = 4'd0;
    bus.rsp_ready = 1'b1;
    #2;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_fields", 64'({bus.rsp_y, bus.rsp_eq, bus.rsp_lt_s, bus.rsp_lt_u, bus.rsp_tag, bus.rsp_err} != '0), 64'd0);
    check("rst_alu", 64'({alu_a, alu_b, alu_op, alu_shamt} != '0), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // cmd, a, d, shamt, swap, tag, latency, y, eq, lt_s, lt_u, err
    do_txn(4'd1, 48'd5, 48'd7, 6'd0, 1'b1, 4'd1, 1, 48'hFFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b0);
    do_txn(4'd0, 48'h7FFF_FFFF_FFFF, 48'd1, 6'd0, 1'b1, 4'd2, 1, 48'h8000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    do_txn(4'd2, 48'hF0F0_F0F0_F0F0, 48'hFF00_FF00_FF00, 6'd0, 1'b0, 4'd3, 1, 48'hF000_F000_F000, 1'b0, 1'b1, 1'b1, 1'b0);
    do_txn(4'd4, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 6'd0, 1'b0, 4'd4, 1, 48'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_txn(4'd7, 48'h8000_0000_0000, 48'h0, 6'd4, 1'b0, 4'd5, 1, 48'hF800_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    do_txn(4'd6, 48'h8000_0000_0000, 48'h0, 6'd47, 1'b0, 4'd6, 1, 48'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    do_txn(4'd5, 48'h1, 48'h0, 6'd47, 1'b0, 4'd7, 1, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    do_txn(4'd8, 48'h0, 48'h0, 6'd0, 1'b0, 4'd8, 1, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    do_txn(4'd5, 48'h1, 48'h0, 6'd50, 1'b0, 4'd9, 0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_txn(4'd6, 48'h1, 48'h0, 6'd48, 1'b0, 4'd10, 0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_txn(4'd12, 48'h1, 48'h2, 6'd0, 1'b0, 4'd11, 0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ALU48_ISSUE_ROTATE_EN
    do_txn(4'd9, 48'h8000_0000_0001, 48'h0, 6'd4, 1'b0, 4'd12, 3, 48'h0000_0000_0018, 1'b0, 1'b1, 1'b0, 1'b0);
    do_txn(4'd10, 48'h8000_0000_0001, 48'h0, 6'd4, 1'b0, 4'd13, 3, 48'h1800_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    do_txn(4'd9, 48'h8000_0000_0001, 48'h0, 6'd0, 1'b0, 4'd14, 1, 48'h8000_0000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
    do_txn(4'd10, 48'h1, 48'h0, 6'd48, 1'b0, 4'd15, 0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    do_txn(4'd9, 48'h8000_0000_0001, 48'h0, 6'd4, 1'b0, 4'd12, 0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_txn(4'd10, 48'h8000_0000_0001, 48'h0, 6'd4, 1'b0, 4'd13, 0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Backpressure, then accept a waiting request on the edge the response drains.
    cur_tag = 5;
    bus.rsp_ready = 1'b0;
    drive_req(4'd3, 48'h0F, 48'hF0, 6'd0, 1'b0, 4'd5);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_valid", 64'(bus.rsp_valid), 64'd1);
    drive_req(4'd0, 48'd2, 48'd3, 6'd0, 1'b0, 4'd6);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_hold_y", 64'(bus.rsp_y), 64'hFF);
      check("bp_hold_tag", 64'(bus.rsp_tag), 64'd5);
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    $display("txn tag=5 cmd=3 held 3 cycles y=%h", bus.rsp_y);
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    cur_tag = 6;
    check("b2b_gap", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    check("b2b_valid", 64'(bus.rsp_valid), 64'd1);
    check("b2b_tag", 64'(bus.rsp_tag), 64'd6);
    check("b2b_y", 64'(bus.rsp_y), 64'd5);
    $display("txn tag=6 cmd=0 back-to-back y=%h", bus.rsp_y);
    @(posedge clk);
    #1;

    // Reset while an operation is in flight.
    cur_tag = 7;
`ifdef ALU48_ISSUE_ROTATE_EN
    drive_req(4'd9, 48'h8000_0000_0001, 48'h0, 6'd4, 1'b0, 4'd7);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
`else
    drive_req(4'd0, 48'd9, 48'd9, 6'd0, 1'b0, 4'd7);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    check("midrst_rsp", 64'({bus.rsp_valid, bus.rsp_y, bus.rsp_eq, bus.rsp_lt_s, bus.rsp_lt_u, bus.rsp_tag, bus.rsp_err} != '0), 64'd0);
    check("midrst_alu", 64'({alu_a, alu_b, alu_op, alu_shamt} != '0), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("midrst_no_stale", 64'(seen), 64'd0);
    $display("txn tag=7 reset mid-operation, stale response seen=%0b", seen);

    do_txn(4'd1, 48'd10, 48'd3, 6'd0, 1'b0, 4'd8, 1, 48'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
